// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DBIT data bits LSB-first, SB_TICK-tick stop period.
// Each byte is presented on rx_dout with a one-cycle rx_done pulse and a framing-error flag.
module uart_rx #(
   parameter int DBIT      = 8,
   parameter int BIT_WIDTH = 16,
   parameter int SB_TICK   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done,
   output logic            frame_err
);

   localparam int CMAX = (BIT_WIDTH > SB_TICK) ? BIT_WIDTH : SB_TICK;
   localparam int SW   = $clog2(CMAX);
   localparam int NW   = $clog2(DBIT);

   localparam logic [SW-1:0] HALF_LAST = SW'(BIT_WIDTH / 2 - 1);
   localparam logic [SW-1:0] BIT_LAST  = SW'(BIT_WIDTH - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [SW-1:0]   s_cnt, s_cnt_n;
   logic [NW-1:0]   n_cnt, n_cnt_n;
   logic [DBIT-1:0] b_reg, b_reg_n;
   logic [DBIT-1:0] dout_n;
   logic            done_n, ferr_n;
   logic [1:0]      sync;
   logic            rx_s;

   // rx is asynchronous; two flops before any decision is made on it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], rx};
   end
   assign rx_s = sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s_cnt     <= '0;
         n_cnt     <= '0;
         b_reg     <= '0;
         rx_dout   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         s_cnt     <= s_cnt_n;
         n_cnt     <= n_cnt_n;
         b_reg     <= b_reg_n;
         rx_dout   <= dout_n;
         rx_done   <= done_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      s_cnt_n = s_cnt;
      n_cnt_n = n_cnt;
      b_reg_n = b_reg;
      dout_n  = rx_dout;
      ferr_n  = frame_err;
      done_n  = 1'b0;
      case (state)
         // level-sensitive start detect, independent of s_tick
         IDLE: if (!rx_s) begin
            state_n = START;
            s_cnt_n = '0;
         end
         START: if (s_tick) begin
            if (s_cnt == HALF_LAST) begin
               if (!rx_s) begin
                  state_n = DATA;
                  s_cnt_n = '0;
                  n_cnt_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               s_cnt_n = s_cnt + SW'(1);
            end
         end
         DATA: if (s_tick) begin
            if (s_cnt == BIT_LAST) begin
               b_reg_n = {rx_s, b_reg[DBIT-1:1]};
               s_cnt_n = '0;
               if (n_cnt == N_LAST) state_n = STOP;
               else                 n_cnt_n = n_cnt + NW'(1);
            end else begin
               s_cnt_n = s_cnt + SW'(1);
            end
         end
         // leave at mid stop bit so an immediately following start edge is caught
         STOP: if (s_tick) begin
            if (s_cnt == STOP_LAST) begin
               state_n = IDLE;
               dout_n  = b_reg;
               ferr_n  = ~rx_s;
               done_n  = 1'b1;
            end else begin
               s_cnt_n = s_cnt + SW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serializer drives the line, and received bytes are
// checked against a queue of (frame_err, byte) expectations built from what was sent.
module tb_uart_rx;

   localparam int DBIT = 8, BW = 16, SBT = 16;

   logic            clk = 1'b0, rst_n = 1'b0, s_tick = 1'b0, rx = 1'b1;
   logic [DBIT-1:0] rx_dout;
   logic            rx_done, frame_err;

   int n_cmp = 0, n_err = 0;
   int div = 1, tcnt = 0;
   logic [DBIT:0] exp_q[$], got_q[$];

   uart_rx #(.DBIT(DBIT), .BIT_WIDTH(BW), .SB_TICK(SBT)) dut (
      .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx(rx),
      .rx_dout(rx_dout), .rx_done(rx_done), .frame_err(frame_err));

   always #5 clk = ~clk;

   // tick strobe: one clk wide, every div clocks
   always @(posedge clk) begin
      #1;
      tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
      s_tick = (tcnt == 0);
   end

   always @(negedge clk) if (rx_done) got_q.push_back({frame_err, rx_dout});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic b, input int nbits_x2);
      rx = b;
      repeat (BW * div * nbits_x2 / 2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DBIT-1:0] d, input logic stop, input int gap_bits);
      hold(1'b0, 2);
      for (int i = 0; i < DBIT; i++) hold(d[i], 2);
      hold(stop, 2);
      exp_q.push_back({~stop, d});
      if (gap_bits > 0) hold(1'b1, 2 * gap_bits);
      rx = 1'b1;
   endtask

   // wait for every expected byte (bounded), then compare count and contents
   task automatic drain(input string tag);
      int budget;
      budget = 4 * (DBIT + 2) * BW * div;
      while (got_q.size() < exp_q.size() && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      repeat (2 * BW * div) @(posedge clk);
      #1;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [DBIT:0] g, e;
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_data"}, g[DBIT-1:0], e[DBIT-1:0]);
         chk({tag, "_ferr"}, g[DBIT], e[DBIT]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [DBIT-1:0] d;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", rx_dout, 0);
      chk("rst_done", rx_done, 0);
      chk("rst_ferr", frame_err, 0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 1: single clean frame
      send_frame(8'hA5, 1'b1, 2);
      drain("t1");

      // 2: short low glitch is rejected
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      drain("t2_glitch");
      chk("t2_dout_hold", rx_dout, 8'hA5);

      // 3: framing error still delivers the byte, next clean frame clears the flag
      send_frame(8'h3C, 1'b0, 2);
      send_frame(8'h81, 1'b1, 2);
      drain("t3");

      // 4: back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h55, 1'b1, 1);
      drain("t4");
      chk("t4_last", rx_dout, 8'h55);

      // 5: reset in the middle of data bit 4
      d = 8'hC3;
      hold(1'b0, 2);
      for (int i = 0; i < 4; i++) hold(d[i], 2);
      hold(d[4], 1);
      rst_n = 1'b0;
      #1;
      chk("t5_dout", rx_dout, 0);
      chk("t5_done", rx_done, 0);
      chk("t5_ferr", frame_err, 0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(1'b1, 4);
      drain("t5_partial");
      send_frame(8'h7E, 1'b1, 2);
      drain("t5_after");

      // 6: randomized stream with s_tick every 5 clocks
      div = 5;
      hold(1'b1, 2);
      for (int k = 0; k < 48; k++) begin
         d = DBIT'($urandom);
         send_frame(d, 1'b1, $urandom_range(0, 1));
      end
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // absolute time limit so a stuck run still reports
   initial begin
      #(2_000_000 * 10);
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
